// File: rtl/keyboard_pkg.sv
// Shared PS/2 set-2 constants, prefix-FSM states and event word layout
// for the keyboard peripheral.
package keyboard_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EV_W       = 10;
  localparam int EV_BRK_BIT = 9;
  localparam int EV_EXT_BIT = 8;
  localparam int EV_CODE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_e;

  function automatic logic [EV_W-1:0] mk_event(
    input logic       brk,
    input logic       ext,
    input logic [7:0] code
  );
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_BRK_BIT] = brk;
    ev[EV_EXT_BIT] = ext;
    ev[EV_CODE_W-1:0] = code;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case (1'b1)
      do_push && !do_pop: count_d = count_q + 1'b1;
      do_pop && !do_push: count_d = count_q - 1'b1;
      default:            count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Folds PS/2 E0/F0 prefixes into key-event words and queues them for
// CPU polling; DATA reads pop, STATUS reads clear the overflow flag.
module ps2_key_event_queue
  import keyboard_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [13:0] DATA_ADDR   = 14'h3ffe,
  parameter logic [13:0] STATUS_ADDR = 14'h3ffd
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        scancode_valid,
  input  logic [7:0]  scancode,
  input  logic        frame_error,
  input  logic [13:0] address,
  input  logic        read_en,
  output logic [63:0] data
);

  localparam int AW = $clog2(DEPTH);

  kb_state_e        state_q, state_d;
  logic             push;
  logic [EV_W-1:0]  ev;
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic [EV_W-1:0]  fifo_head;
  logic [8:0]       cnt9;
  logic             sel_data, sel_stat, pop;
  logic             is_ext, is_brk;

  assign is_ext = (scancode == PS2_EXT);
  assign is_brk = (scancode == PS2_BRK);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ev      = '0;
    if (frame_error) begin
      state_d = ST_IDLE;
    end else if (scancode_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            is_ext:  state_d = ST_EXT;
            is_brk:  state_d = ST_BRK;
            default: begin
              push = 1'b1;
              ev   = mk_event(1'b0, 1'b0, scancode);
            end
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            is_brk:  state_d = ST_EXT_BRK;
            is_ext:  state_d = ST_EXT;
            default: begin
              push    = 1'b1;
              ev      = mk_event(1'b0, 1'b1, scancode);
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          if (!(is_ext || is_brk)) begin
            push    = 1'b1;
            ev      = mk_event(1'b1, 1'b0, scancode);
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (!(is_ext || is_brk)) begin
            push    = 1'b1;
            ev      = mk_event(1'b1, 1'b1, scancode);
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sel_data = (address == DATA_ADDR);
  assign sel_stat = (address == STATUS_ADDR);
  assign pop      = read_en && sel_data && !fifo_empty;

  // A drop in the clearing cycle must stay visible to the next poll.
  always_comb begin
    ovf_d = ovf_q;
    if (read_en && sel_stat) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (system_clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign cnt9 = 9'(fifo_count);

  always_comb begin
    data = 64'h0;
    unique case (1'b1)
      sel_data: if (!fifo_empty) data = {1'b1, 53'b0, fifo_head};
      sel_stat: data = {ovf_q, 54'b0, cnt9};
      default:  data = 64'h0;
    endcase
  end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Self-checking bench: table of prefix sequences plus hand-written
// sequences for overflow, full push/pop, reset and frame errors.
module tb_ps2_key_event_queue;

  localparam logic [13:0] DA = 14'h3ffe;
  localparam logic [13:0] SA = 14'h3ffd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv = 1'b0;
  logic [7:0]  sc = 8'h0;
  logic        fe = 1'b0;
  logic [13:0] addr = 14'h0;
  logic        ren = 1'b0;
  logic [63:0] data;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb[$];

  ps2_key_event_queue dut (
    .system_clk     (clk),
    .reset          (rst_n),
    .scancode_valid (sv),
    .scancode       (sc),
    .frame_error    (fe),
    .address        (addr),
    .read_en        (ren),
    .data           (data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b[3];
    int         n;
    logic [9:0] ev;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    sv = 1'b1;
    sc = b;
    @(posedge clk);
    #1;
    sv = 1'b0;
  endtask

  task automatic peek(input logic [13:0] a, output logic [63:0] d);
    addr = a;
    #1;
    d = data;
  endtask

  task automatic rd(input logic [13:0] a, output logic [63:0] d);
    addr = a;
    #1;
    d = data;
    ren = 1'b1;
    @(posedge clk);
    #1;
    ren = 1'b0;
    addr = 14'h0;
  endtask

  task automatic pop_chk(input string nm);
    logic [63:0] d;
    logic [9:0]  e;
    rd(DA, d);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", nm, d);
    end else begin
      e = sb.pop_front();
      check(nm, d, {1'b1, 53'b0, e});
    end
  endtask

  task automatic stat_chk(input string nm, input logic ovf,
                          input int cnt);
    logic [63:0] d;
    rd(SA, d);
    check(nm, d, {ovf, 54'b0, 9'(cnt)});
  endtask

  initial begin
    logic [63:0] d;

    vt[0] = '{'{8'h1C, 8'h00, 8'h00}, 1, 10'h01C};
    vt[1] = '{'{8'hF0, 8'h1C, 8'h00}, 2, 10'h21C};
    vt[2] = '{'{8'hE0, 8'hF0, 8'h75}, 3, 10'h375};
    vt[3] = '{'{8'hE0, 8'h74, 8'h00}, 2, 10'h174};
    vt[4] = '{'{8'hF0, 8'hE0, 8'h5A}, 3, 10'h25A};
    vt[5] = '{'{8'hE0, 8'hE0, 8'h11}, 3, 10'h111};

    #2;
    peek(DA, d);
    check("reset_data", d, 64'h0);
    peek(SA, d);
    check("reset_status", d, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vt[i].n; j++) begin
        if (j == vt[i].n - 1) sb.push_back(vt[i].ev);
        send(vt[i].b[j]);
      end
      stat_chk($sformatf("vec%0d_count", i), 1'b0, 1);
      pop_chk($sformatf("vec%0d_event", i));
      stat_chk($sformatf("vec%0d_after", i), 1'b0, 0);
    end

    rd(DA, d);
    check("empty_read", d, 64'h0);
    stat_chk("empty_pop_noeffect", 1'b0, 0);

    send(8'hF0);
    stat_chk("brk_prefix_nopush", 1'b0, 0);
    sb.push_back(10'h21C);
    send(8'h1C);
    peek(14'h0123, d);
    check("other_addr", d, 64'h0);
    stat_chk("brk_count1", 1'b0, 1);
    pop_chk("brk_event");

    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) sb.push_back(10'(k));
      send(8'(k));
    end
    stat_chk("ovf_status", 1'b1, 16);
    stat_chk("ovf_cleared", 1'b0, 16);

    addr = DA;
    #1;
    d = data;
    check("full_pp_head", d, {1'b1, 53'b0, sb.pop_front()});
    sb.push_back(10'h022);
    ren = 1'b1;
    sv = 1'b1;
    sc = 8'h22;
    @(posedge clk);
    #1;
    ren = 1'b0;
    sv = 1'b0;
    stat_chk("full_pp_count", 1'b0, 16);

    addr = SA;
    ren = 1'b1;
    sv = 1'b1;
    sc = 8'h33;
    @(posedge clk);
    #1;
    ren = 1'b0;
    sv = 1'b0;
    stat_chk("ovf_during_clear", 1'b1, 16);

    for (int k = 0; k < 16; k++) pop_chk($sformatf("drain%0d", k));
    rd(DA, d);
    check("drain_empty", d, 64'h0);

    send(8'hE0);
    rst_n = 1'b0;
    #3;
    peek(SA, d);
    check("midreset_status", d, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(10'h01C);
    send(8'h1C);
    pop_chk("after_reset_event");

    send(8'hE0);
    fe = 1'b1;
    @(posedge clk);
    #1;
    fe = 1'b0;
    sb.push_back(10'h074);
    send(8'h74);
    pop_chk("after_fe_event");

    fe = 1'b1;
    send(8'h1C);
    fe = 1'b0;
    stat_chk("fe_wins", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
